// File: rtl/core_bus_pkg.sv
// Shared constants for the core data-port responder: MMIO page layout and
// console status bit positions, plus a helper that packs the status word.
package core_bus_pkg;

  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h8000_0000;

  localparam logic [11:0] OFS_GPIO      = 12'h000;
  localparam logic [11:0] OFS_CONS_TX   = 12'h004;
  localparam logic [11:0] OFS_CONS_STAT = 12'h008;
  localparam logic [11:0] OFS_CONS_CLR  = 12'h00C;
  localparam logic [11:0] OFS_CYC_SNAP  = 12'h010;
  localparam logic [11:0] OFS_SNAP_LO   = 12'h014;
  localparam logic [11:0] OFS_SNAP_HI   = 12'h018;

  localparam int unsigned STAT_EMPTY_BIT = 0;
  localparam int unsigned STAT_FULL_BIT  = 1;
  localparam int unsigned STAT_OVF_BIT   = 2;
  localparam int unsigned STAT_COUNT_LSB = 8;

  function automatic logic [31:0] cons_stat(input logic       empty,
                                            input logic       full,
                                            input logic       ovf,
                                            input logic [7:0] cnt);
    logic [31:0] r;
    r                       = '0;
    r[STAT_EMPTY_BIT]       = empty;
    r[STAT_FULL_BIT]        = full;
    r[STAT_OVF_BIT]         = ovf;
    r[STAT_COUNT_LSB +: 8]  = cnt;
    return r;
  endfunction

endpackage

// File: rtl/console_fifo.sv
// Byte FIFO for the console transmit path. A push into a full FIFO is still
// accepted when a pop happens on the same edge; otherwise it is dropped.
module console_fifo #(
  parameter  int unsigned DEPTH = 8,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic [7:0]    push_data_i,
  input  logic          pop_i,
  output logic [7:0]    head_o,
  output logic          empty_o,
  output logic          full_o,
  output logic [CW-1:0] count_o,
  output logic          drop_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  assign count_o = count_q;

  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign drop_o  = push_i && !do_push;

  // Head reads 0 when empty so the output is defined straight out of reset.
  assign head_o  = empty_o ? 8'h00 : mem_q[rd_q];

  always_comb begin
    rd_d    = do_pop  ? rd_q + AW'(1) : rd_q;
    wr_d    = do_push ? wr_q + AW'(1) : wr_q;
    count_d = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q    <= '0;
      wr_q    <= '0;
      count_q <= '0;
    end else begin
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data_i;
  end

endmodule

// File: rtl/data_bus_responder.sv
// Data-port responder for the single-cycle core: word RAM plus an MMIO page
// with GPIO, console TX FIFO and a 64-bit cycle counter with snapshot.
module data_bus_responder
  import core_bus_pkg::*;
#(
  parameter int unsigned RAM_WORDS  = 256,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        cons_valid,
  output logic [7:0]  cons_data,
  input  logic        cons_ready,
  output logic [31:0] gpio_out
);

  localparam int unsigned RAM_AW    = $clog2(RAM_WORDS);
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);
  localparam int unsigned CW        = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       ram_q [RAM_WORDS];
  logic [RAM_AW-1:0] ram_idx;
  logic              ram_hit, mmio_hit;
  logic [9:0]        ofs_word;

  logic [31:0] gpio_q, gpio_d;
  logic        ovf_q, ovf_d;
  logic [63:0] cyc_q, cyc_d;
  logic [63:0] snap_q, snap_d;

  logic          gpio_we, tx_we, clr_we, snap_we;
  logic          cons_empty, cons_full, cons_drop, cons_pop;
  logic [CW-1:0] cons_count;

  assign ram_hit  = (ALUResult < RAM_BYTES);
  assign ram_idx  = ALUResult[RAM_AW+1:2];
  assign mmio_hit = (ALUResult[31:12] == MMIO_BASE[31:12]);
  assign ofs_word = ALUResult[11:2];

  assign gpio_we = MemWrite && mmio_hit && (ofs_word == OFS_GPIO[11:2]);
  assign tx_we   = MemWrite && mmio_hit && (ofs_word == OFS_CONS_TX[11:2]);
  assign clr_we  = MemWrite && mmio_hit && (ofs_word == OFS_CONS_CLR[11:2]);
  assign snap_we = MemWrite && mmio_hit && (ofs_word == OFS_CYC_SNAP[11:2]);

  // Console drain handshake: a byte transfers on every rising edge where
  // cons_valid and cons_ready are both high; cons_data holds until then.
  assign cons_valid = !cons_empty;
  assign cons_pop   = cons_valid && cons_ready;

  console_fifo #(.DEPTH(FIFO_DEPTH)) u_cons_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (tx_we),
    .push_data_i (WriteData[7:0]),
    .pop_i       (cons_pop),
    .head_o      (cons_data),
    .empty_o     (cons_empty),
    .full_o      (cons_full),
    .count_o     (cons_count),
    .drop_o      (cons_drop)
  );

  always_comb begin
    gpio_d = gpio_we ? WriteData : gpio_q;
    // A drop on the same edge as a clear wins, so no overflow is lost.
    ovf_d  = cons_drop ? 1'b1 : (clr_we ? 1'b0 : ovf_q);
    cyc_d  = cyc_q + 64'd1;
    snap_d = snap_we ? cyc_q : snap_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gpio_q <= '0;
      ovf_q  <= 1'b0;
      cyc_q  <= '0;
      snap_q <= '0;
    end else begin
      gpio_q <= gpio_d;
      ovf_q  <= ovf_d;
      cyc_q  <= cyc_d;
      snap_q <= snap_d;
    end
  end

  always_ff @(posedge clk) begin
    if (MemWrite && ram_hit) ram_q[ram_idx] <= WriteData;
  end

  assign gpio_out = gpio_q;

  always_comb begin
    ReadData = '0;
    if (ram_hit) begin
      ReadData = ram_q[ram_idx];
    end else if (mmio_hit) begin
      case (ofs_word)
        OFS_GPIO[11:2]:      ReadData = gpio_q;
        OFS_CONS_STAT[11:2]: ReadData = cons_stat(cons_empty, cons_full, ovf_q,
                                                  8'(cons_count));
        OFS_SNAP_LO[11:2]:   ReadData = snap_q[31:0];
        OFS_SNAP_HI[11:2]:   ReadData = snap_q[63:32];
        default:             ReadData = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_data_bus_responder.sv
// Bench for data_bus_responder: directed cases with literal expectations plus
// a randomized phase, all outputs compared every cycle against a queue model.
module tb_data_bus_responder;

  localparam logic [31:0] MB        = 32'h8000_0000;
  localparam logic [31:0] A_GPIO    = MB + 32'h00;
  localparam logic [31:0] A_TX      = MB + 32'h04;
  localparam logic [31:0] A_STAT    = MB + 32'h08;
  localparam logic [31:0] A_CLR     = MB + 32'h0C;
  localparam logic [31:0] A_SNAP    = MB + 32'h10;
  localparam logic [31:0] A_SNAP_LO = MB + 32'h14;
  localparam logic [31:0] A_SNAP_HI = MB + 32'h18;
  localparam int          DEPTH     = 8;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic [31:0] ReadData;
  logic        cons_valid;
  logic [7:0]  cons_data;
  logic        cons_ready;
  logic [31:0] gpio_out;

  int tests = 0;
  int fails = 0;

  // Behavioural model state
  logic [31:0] ram_m [256];
  bit          ram_v [256];
  logic [7:0]  exp_q [$];
  logic [31:0] gpio_m = '0;
  bit          ovf_m  = 1'b0;
  logic [63:0] cyc_m  = '0;
  logic [63:0] snap_m = '0;

  data_bus_responder dut (
    .clk        (clk),
    .reset      (reset),
    .MemWrite   (MemWrite),
    .ALUResult  (ALUResult),
    .WriteData  (WriteData),
    .ReadData   (ReadData),
    .cons_valid (cons_valid),
    .cons_data  (cons_data),
    .cons_ready (cons_ready),
    .gpio_out   (gpio_out)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    reset      = 1'b1;
    MemWrite   = 1'b0;
    ALUResult  = A_STAT;
    WriteData  = '0;
    cons_ready = 1'b0;
    for (int i = 0; i < 256; i++) ram_v[i] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] model_read(input logic [31:0] a, output bit known);
    logic [11:0] off;
    int          sz;
    known = 1'b1;
    off   = a[11:0] & 12'hFFC;
    sz    = exp_q.size();
    if (a < 32'd1024) begin
      known = ram_v[a[9:2]];
      return ram_m[a[9:2]];
    end
    if (a[31:12] != MB[31:12]) return 32'h0;
    case (off)
      12'h000: return gpio_m;
      12'h008: return 32'((sz == 0) ? 1 : 0) + 32'((sz == DEPTH) ? 2 : 0)
                    + 32'(ovf_m ? 4 : 0) + 32'(sz * 256);
      12'h014: return snap_m[31:0];
      12'h018: return snap_m[63:32];
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_step();
    int          sz;
    bit          popped, ovf_evt, clr;
    logic [11:0] off;
    if (reset) begin
      exp_q.delete();
      ovf_m  = 1'b0;
      gpio_m = '0;
      cyc_m  = '0;
      snap_m = '0;
      return;
    end
    sz      = exp_q.size();
    popped  = (sz > 0) && cons_ready;
    ovf_evt = 1'b0;
    clr     = 1'b0;
    off     = ALUResult[11:0] & 12'hFFC;
    if (popped) void'(exp_q.pop_front());
    if (MemWrite) begin
      if (ALUResult < 32'd1024) begin
        ram_m[ALUResult[9:2]] = WriteData;
        ram_v[ALUResult[9:2]] = 1'b1;
      end else if (ALUResult[31:12] == MB[31:12]) begin
        case (off)
          12'h000: gpio_m = WriteData;
          12'h004: if (sz < DEPTH || popped) exp_q.push_back(WriteData[7:0]);
                   else ovf_evt = 1'b1;
          12'h00C: clr = 1'b1;
          12'h010: snap_m = cyc_m;
          default: ;
        endcase
      end
    end
    if (clr) ovf_m = 1'b0;
    if (ovf_evt) ovf_m = 1'b1;
    cyc_m = cyc_m + 64'd1;
  endtask

  // Scoreboard: compare before each rising edge, then advance the model.
  initial begin
    bit          known;
    logic [31:0] exp_rd;
    forever begin
      @(negedge clk);
      #3;
      if (!reset) begin
        exp_rd = model_read(ALUResult, known);
        if (known) check("ReadData", ReadData, exp_rd);
        check("cons_valid", 32'(cons_valid), 32'(exp_q.size() != 0));
        check("cons_data", 32'(cons_data), (exp_q.size() != 0) ? 32'(exp_q[0]) : 32'h0);
        check("gpio_out", gpio_out, gpio_m);
      end
      @(posedge clk);
      model_step();
    end
  end

  // Driver
  task automatic bus(input logic we, input logic [31:0] addr,
                     input logic [31:0] data, input logic rdy);
    @(negedge clk);
    MemWrite   = we;
    ALUResult  = addr;
    WriteData  = data;
    cons_ready = rdy;
  endtask

  initial begin
    logic [31:0] addr;
    int          kind;
    logic        we;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_gpio", gpio_out, 32'h0);
    check("rst_valid", 32'(cons_valid), 32'h0);
    check("rst_data", 32'(cons_data), 32'h0);
    check("rst_stat", ReadData, 32'h0000_0001);
    @(negedge clk);
    reset = 1'b0;

    // RAM store/load
    bus(1, 32'h0000_0010, 32'hCAFE_F00D, 0);
    bus(0, 32'h0000_0011, 32'h0, 0);
    #4 check("ram_load", ReadData, 32'hCAFE_F00D);
    bus(0, 32'h0000_0400, 32'h0, 0);
    #4 check("ram_oor", ReadData, 32'h0);

    // GPIO
    bus(1, A_GPIO, 32'h0000_00A5, 0);
    bus(0, A_GPIO, 32'h0, 0);
    #4 check("gpio_out", gpio_out, 32'h0000_00A5);
    check("gpio_read", ReadData, 32'h0000_00A5);

    // Console drain
    bus(1, A_TX, 32'h0000_0048, 0);
    bus(1, A_TX, 32'h0000_0069, 0);
    bus(0, A_STAT, 32'h0, 0);
    #4 check("stat_two", ReadData, 32'h0000_0200);
    bus(0, A_STAT, 32'h0, 1);
    #4 check("drain0", 32'(cons_data), 32'h48);
    bus(0, A_STAT, 32'h0, 1);
    #4 check("drain1", 32'(cons_data), 32'h69);
    bus(0, A_STAT, 32'h0, 1);
    #4 check("drain_empty", 32'(cons_valid), 32'h0);
    check("stat_empty", ReadData, 32'h0000_0001);

    // Overflow, clear, push-on-pop when full
    for (int i = 0; i < 9; i++) bus(1, A_TX, 32'hB0 + 32'(i), 0);
    bus(0, A_STAT, 32'h0, 0);
    #4 check("stat_ovf", ReadData, 32'h0000_0806);
    bus(1, A_CLR, 32'h0, 0);
    bus(0, A_STAT, 32'h0, 0);
    #4 check("stat_clr", ReadData, 32'h0000_0802);
    bus(1, A_TX, 32'h0000_00C8, 1);
    #4 check("pop_head", 32'(cons_data), 32'hB0);
    bus(0, A_STAT, 32'h0, 0);
    #4 check("stat_pushpop", ReadData, 32'h0000_0802);
    for (int i = 1; i < 9; i++) begin
      bus(0, A_STAT, 32'h0, 1);
      #4 check("drain_full", 32'(cons_data), (i < 8) ? 32'hB0 + 32'(i) : 32'hC8);
    end
    bus(0, A_STAT, 32'h0, 1);
    #4 check("drain_done", 32'(cons_valid), 32'h0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      kind = int'($urandom_range(0, 9));
      we   = 1'($urandom_range(0, 1));
      case (kind)
        0, 1, 2: addr = 32'($urandom_range(0, 255)) * 4 + 32'($urandom_range(0, 3));
        3, 4, 5: addr = MB + 32'($urandom_range(0, 8)) * 4 + 32'($urandom_range(0, 3));
        6: begin addr = A_TX; we = 1'b1; end
        7: addr = 32'h400 + 32'($urandom_range(0, 16'hFFFF));
        8: addr = $urandom;
        default: addr = MB + 32'($urandom_range(12'h20, 12'hFFF));
      endcase
      bus(we, addr, $urandom, 1'($urandom_range(0, 2) == 0));
    end

    // Reset mid-operation
    bus(1, 32'h0000_0020, 32'h1234_5678, 0);
    bus(1, A_GPIO, 32'h5A5A_5A5A, 0);
    bus(1, A_TX, 32'h11, 0);
    bus(1, A_TX, 32'h22, 0);
    @(negedge clk);
    MemWrite  = 1'b0;
    ALUResult = A_STAT;
    #2 reset = 1'b1;
    #1;
    check("mid_rst_gpio", gpio_out, 32'h0);
    check("mid_rst_valid", 32'(cons_valid), 32'h0);
    check("mid_rst_data", 32'(cons_data), 32'h0);
    check("mid_rst_stat", ReadData, 32'h0000_0001);

    // Counter snapshot after release
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(posedge clk);
    bus(1, A_SNAP, 32'h0, 0);
    bus(0, A_SNAP_LO, 32'h0, 0);
    #4 check("snap_lo10", ReadData, 32'd10);
    bus(0, A_SNAP_HI, 32'h0, 0);
    #4 check("snap_hi10", ReadData, 32'h0);
    bus(0, 32'h0000_0020, 32'h0, 0);
    #4 check("ram_keep", ReadData, 32'h1234_5678);

    // Counter wrap: snapshot on the edge after the all-ones value
    @(negedge clk);
    dut.cyc_q <= '1;
    cyc_m      = '1;
    bus(1, A_SNAP, 32'h0, 0);
    bus(0, A_SNAP_LO, 32'h0, 0);
    #4 check("wrap_lo", ReadData, 32'h0);
    bus(0, A_SNAP_HI, 32'h0, 0);
    #4 check("wrap_hi", ReadData, 32'h0);

    // Snapshot on the wrapping edge captures the pre-increment value
    @(negedge clk);
    dut.cyc_q <= '1;
    cyc_m      = '1;
    MemWrite   = 1'b1;
    ALUResult  = A_SNAP;
    bus(0, A_SNAP_LO, 32'h0, 0);
    #4 check("ones_lo", ReadData, 32'hFFFF_FFFF);
    bus(0, A_SNAP_HI, 32'h0, 0);
    #4 check("ones_hi", ReadData, 32'hFFFF_FFFF);

    bus(0, A_STAT, 32'h0, 0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
